// File: rtl/cpu_ctrl_pkg.sv
// Shared types and default sizing for the single-step / run controller.
package cpu_ctrl_pkg;

  localparam int SAMPLE_DIV_DFLT = 4;
  localparam int RUN_DIV_DFLT    = 3;
  localparam int CNT_W_DFLT      = 16;

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_STEP = 2'b01,
    ST_RUN  = 2'b10
  } step_state_e;

  // Bits needed to hold a counter running 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchronizer, tick-paced two-stage sample shift,
// pressed flag with hysteresis, and a one-cycle press pulse.
module btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic tick_i,
  output logic press_o
);

  logic sync1_q;
  logic sync2_q;
  logic s0_q;
  logic s1_q;
  logic pressed_q;
  logic pressed_d;
  logic press_q;

  // Bring the raw asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Sample shift advances only on the shared slow tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else if (tick_i) begin
      s0_q <= sync2_q;
      s1_q <= s0_q;
    end else begin
      s0_q <= s0_q;
      s1_q <= s1_q;
    end
  end

  // Pressed flag: set on two agreeing high samples, clear on two low ones.
  always_comb begin
    pressed_d = pressed_q;
    if (s0_q && s1_q) begin
      pressed_d = 1'b1;
    end else if (!(s0_q || s1_q)) begin
      pressed_d = 1'b0;
    end else begin
      pressed_d = pressed_q;
    end
  end

  // Register the flag and emit one pulse on its rising transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      pressed_q <= pressed_d;
      press_q   <= pressed_d & ~pressed_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Processor clock-enable controller: debounced step and run/halt buttons
// drive a HALT/STEP/RUN FSM that paces cpu_en and counts issued enables.
module cpu_step_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DFLT,
  parameter int RUN_DIV    = RUN_DIV_DFLT,
  parameter int CNT_W      = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_step,
  input  logic             btn_run,
  input  logic             cpu_halt,
  output logic             cpu_en,
  output logic             running,
  output logic [CNT_W-1:0] step_cnt
);

  localparam int TW = cnt_width(SAMPLE_DIV);
  localparam int RW = cnt_width(RUN_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(SAMPLE_DIV);
  localparam logic [RW-1:0] RUN_MAX  = RW'(RUN_DIV);

  logic [TW-1:0]    tick_cnt_q;
  logic [TW-1:0]    tick_cnt_d;
  logic             tick_s;
  logic             step_press_s;
  logic             run_press_s;
  step_state_e      state_q;
  step_state_e      state_d;
  logic [RW-1:0]    run_cnt_q;
  logic [RW-1:0]    run_cnt_d;
  logic             cpu_en_s;
  logic [CNT_W-1:0] step_cnt_q;

  assign tick_s = (tick_cnt_q == TICK_MAX);

  // Free-running sample divider: wraps to zero after the tick cycle.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (tick_s) begin
      tick_cnt_d = {TW{1'b0}};
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // Sample divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= {TW{1'b0}};
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  btn_debounce u_step_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_step),
    .tick_i  (tick_s),
    .press_o (step_press_s)
  );

  btn_debounce u_run_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (btn_run),
    .tick_i  (tick_s),
    .press_o (run_press_s)
  );

  // FSM next state, run pacing and cpu_en decode from registered state.
  always_comb begin
    state_d   = state_q;
    run_cnt_d = run_cnt_q;
    cpu_en_s  = 1'b0;
    case (state_q)
      ST_HALT: begin
        // Hold the pacing counter at zero so RUN always starts a full period.
        run_cnt_d = {RW{1'b0}};
        if (!cpu_halt && run_press_s) begin
          state_d = ST_RUN;
        end else if (!cpu_halt && step_press_s) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_HALT;
        end
      end
      ST_STEP: begin
        cpu_en_s = 1'b1;
        state_d  = ST_HALT;
      end
      ST_RUN: begin
        if (run_press_s || cpu_halt) begin
          // Stopping wins over a due pulse in the same cycle.
          state_d   = ST_HALT;
          run_cnt_d = {RW{1'b0}};
        end else if (run_cnt_q == RUN_MAX) begin
          cpu_en_s  = 1'b1;
          run_cnt_d = {RW{1'b0}};
        end else begin
          run_cnt_d = run_cnt_q + RW'(1);
        end
      end
      default: begin
        state_d   = ST_HALT;
        run_cnt_d = {RW{1'b0}};
      end
    endcase
  end

  // FSM state and run pacing registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_HALT;
      run_cnt_q <= {RW{1'b0}};
    end else begin
      state_q   <= state_d;
      run_cnt_q <= run_cnt_d;
    end
  end

  // Count every issued enable, wrapping naturally at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_q <= {CNT_W{1'b0}};
    end else if (cpu_en_s) begin
      step_cnt_q <= step_cnt_q + CNT_W'(1);
    end else begin
      step_cnt_q <= step_cnt_q;
    end
  end

  assign cpu_en   = cpu_en_s;
  assign running  = (state_q == ST_RUN);
  assign step_cnt = step_cnt_q;

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 4, meaning the button sample tick fires every SAMPLE_DIV+1 clk cycles.
REQ-002 SHALL have parameter RUN_DIV, default 3, meaning one cpu_en pulse is issued every RUN_DIV+1 clk cycles in RUN.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of step_cnt.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port btn_step, input, 1, raw asynchronous single-step button; high means pressed.
REQ-007 SHALL have port btn_run, input, 1, raw asynchronous run/halt toggle button; high means pressed.
REQ-008 SHALL have port cpu_halt, input, 1, level from the processor requesting a stop (halt instruction).
REQ-009 SHALL have port cpu_en, output, 1, processor clock enable; each high cycle advances the processor one instruction.
REQ-010 SHALL have port running, output, 1, high while the FSM is in RUN.
REQ-011 SHALL have port step_cnt, output, CNT_W, count of cpu_en cycles issued since reset.

Function
REQ-012 SHALL run a tick counter 0..SAMPLE_DIV; tick is high in the cycle the counter equals SAMPLE_DIV; the counter then returns to 0.
REQ-013 SHALL pass each button through a 2-FF synchronizer, then a 2-stage sample shift (s0, s1) that updates only on tick.
REQ-014 SHALL keep a per-button pressed flag: set when s0&s1=1, cleared when s0|s1=0, otherwise held.
REQ-015 SHALL emit a per-button press pulse of exactly one clk cycle on each 0->1 transition of the pressed flag; a glitch spanning at most one tick yields no pulse.
REQ-016 SHALL implement FSM states HALT, STEP, RUN.
REQ-017 In HALT, SHALL go to RUN on a run press and to STEP on a step press, both only when cpu_halt=0; on a simultaneous run and step press SHALL go to RUN; with cpu_halt=1 SHALL stay in HALT.
REQ-018 STEP SHALL last exactly one cycle with cpu_en=1, then return to HALT unconditionally.
REQ-019 On entering RUN, SHALL clear run_cnt (range 0..RUN_DIV) to 0; in RUN, cpu_en=1 exactly when run_cnt=RUN_DIV and cpu_halt=0.
REQ-020 In RUN, a run press or cpu_halt=1 SHALL cause HALT next cycle and SHALL suppress any cpu_en in that same cycle.
REQ-021 In RUN, step presses SHALL be ignored; in STEP, all presses SHALL be ignored and discarded.
REQ-022 cpu_en SHALL be decoded from registered state and run_cnt (plus cpu_halt), and SHALL be 0 in HALT.
REQ-023 step_cnt SHALL increment by 1 on every cycle with cpu_en=1, wrapping from 2^CNT_W-1 to 0.
REQ-024 running SHALL equal (state==RUN).

Reset
REQ-025 While rst_n=0, SHALL hold the state at HALT and zero all counters, synchronizers, sample stages, pressed flags and step_cnt; cpu_en and running SHALL read 0.
REQ-026 Asserting rst_n mid-RUN or mid-STEP SHALL force cpu_en to 0 immediately; no pulse SHALL be issued after release until a new press.

Structure
REQ-027 Package cpu_ctrl_pkg SHALL hold the FSM state enum and the default SAMPLE_DIV, RUN_DIV and CNT_W constants.
REQ-028 Sub-module btn_debounce (synchronizer, sample stages, pressed flag, pulse) SHALL be instantiated once per button and SHALL take the shared tick as an input.

Verification (SAMPLE_DIV=4, RUN_DIV=3, CNT_W=16)
REQ-029 btn_step high for 30 cycles from HALT -> exactly one cpu_en cycle, step_cnt 0->1, running stays 0.
REQ-030 btn_step high for 3 cycles (glitch) -> no press pulse, no cpu_en, step_cnt stays 0.
REQ-031 Run press -> cpu_en on every 4th cycle; second run press after 3 pulses -> HALT, step_cnt=3, no further cpu_en.
REQ-032 cpu_halt=1 asserted in RUN on the cycle where run_cnt=3 -> no cpu_en that cycle, HALT next cycle; run press with cpu_halt=1 -> stays HALT.
REQ-033 Step and run presses landing in the same cycle from HALT -> RUN; step_cnt preloaded to 0xFFFF by forcing plus one pulse -> 0x0000.
REQ-034 rst_n=0 mid-RUN -> cpu_en=0 and running=0 asynchronously, step_cnt=0; after release with buttons idle -> remains HALT.
